// File: rtl/s1423_cmp_serial.sv
// ============================================================================
// s1423_cmp_serial : bit-serial (LSB-first) magnitude compare with qualifier
//                    and saturating hit counter.   Rev 1.0
// ============================================================================
`default_nettype none

module s1423_cmp_serial #(
  parameter int WIDTH = 5,
  parameter int CNT_W = 8
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             start,
  output logic             ready,
  input  logic             sel,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             qual,
  output logic             done,
  output logic             result,
  output logic [CNT_W-1:0] hits,
  input  logic             clr
);

  localparam int              IDX_W = $clog2(WIDTH + 1);
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [1:0]       op_q;
  logic             qual_q;
  logic             gt_q, lt_q;
  logic [IDX_W-1:0] idx_q;
  logic             ready_q, done_q, result_q;
  logic [CNT_W-1:0] hits_q;
  logic             cmp_d;
  logic             hit_d;

  always_comb begin
    cmp_d = 1'b0;
    case (op_q)
      2'd0:    cmp_d = gt_q;
      2'd1:    cmp_d = ~lt_q;
      2'd2:    cmp_d = ~gt_q & ~lt_q;
      default: cmp_d = lt_q;
    endcase
    hit_d = cmp_d & qual_q;
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= 2'd0;
      qual_q   <= 1'b0;
      gt_q     <= 1'b0;
      lt_q     <= 1'b0;
      idx_q    <= '0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      result_q <= 1'b0;
      hits_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= sel ? a1 : a0;
            b_q     <= b;
            op_q    <= op;
            qual_q  <= qual;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            idx_q   <= '0;
            ready_q <= 1'b0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          // Operands shift right so bit 0 is always the current bit; later
          // (more significant) differences overwrite earlier ones.
          if (a_q[0] & ~b_q[0]) begin
            gt_q <= 1'b1;
            lt_q <= 1'b0;
          end else if (~a_q[0] & b_q[0]) begin
            gt_q <= 1'b0;
            lt_q <= 1'b1;
          end
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          idx_q <= idx_q + IDX_W'(1);
          if (idx_q == LAST) state_q <= DONE;
        end
        DONE: begin
          result_q <= hit_d;
          done_q   <= 1'b1;
          ready_q  <= 1'b1;
          state_q  <= IDLE;
          if (hit_d && (hits_q != {CNT_W{1'b1}})) hits_q <= hits_q + CNT_W'(1);
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
      // Clear wins over a same-edge increment.
      if (clr) hits_q <= '0;
    end
  end

  assign ready  = ready_q;
  assign done   = done_q;
  assign result = result_q;
  assign hits   = hits_q;

endmodule

`default_nettype wire
